// File: rtl/glcm_pkg.sv
// Shared constants, FSM encoding and burst-sizing helper for the GLCM matrix reader.
package glcm_pkg;

  localparam logic [2:0] AXSIZE_4B    = 3'b010;
  localparam logic [1:0] AXBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  localparam int N_WORDS    = 64;
  localparam int BURST_MAX  = 16;
  localparam int PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DRAIN
  } state_e;

  // Beats in the next burst: capped by the AXI burst limit, the words still
  // to fetch, and the words left before the next 4 KB page boundary.
  function automatic logic [4:0] burst_len(input logic [6:0]  words_left,
                                           input logic [11:0] page_off);
    logic [10:0] room_words;
    logic [10:0] len;
    room_words = 11'((13'(PAGE_BYTES) - {1'b0, page_off}) >> 2);
    len        = 11'(BURST_MAX);
    if ({4'b0, words_left} < len) len = {4'b0, words_left};
    if (room_words < len)         len = room_words;
    return len[4:0];
  endfunction

endpackage

// File: rtl/glcm_word_fifo.sv
// Small synchronous FIFO holding {index, data} words between AXI and the core.
module glcm_word_fifo #(
  parameter  int WIDTH = 38,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the empty flag masks its contents.
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/glcm_matrix_reader.sv
// AXI4 read master: fetches the 16x16 GLCM input matrix as 64 words in
// 4 KB-safe bursts and streams them with their raster index to the core.
module glcm_matrix_reader #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_WORDS    = glcm_pkg::N_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   arid_m_inf,
  output logic [ADDR_WIDTH-1:0] araddr_m_inf,
  output logic [3:0]            arlen_m_inf,
  output logic [2:0]            arsize_m_inf,
  output logic [1:0]            arburst_m_inf,
  output logic                  arvalid_m_inf,
  input  logic                  arready_m_inf,
  input  logic [ID_WIDTH-1:0]   rid_m_inf,
  input  logic [DATA_WIDTH-1:0] rdata_m_inf,
  input  logic [1:0]            rresp_m_inf,
  input  logic                  rlast_m_inf,
  input  logic                  rvalid_m_inf,
  output logic                  rready_m_inf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [5:0]            out_idx
);

  import glcm_pkg::*;

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = DATA_WIDTH + 6;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [6:0]            words_left_q, words_left_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [3:0]            beats_left_q, beats_left_d;
  logic [5:0]            push_idx_q, push_idx_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic                  fifo_full, fifo_empty, fifo_pop, r_fire, last_beat, beat_err, load_burst;
  logic [CNT_W-1:0]      fifo_count;
  logic [FIFO_W-1:0]     fifo_rdata;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [6:0]            src_words;
  logic [4:0]            next_len;

  // cur_addr/words_left always describe the burst still to be issued, so the
  // next burst is sized from them (or from base_addr when starting).
  assign src_addr  = (state_q == ST_IDLE) ? base_addr  : cur_addr_q;
  assign src_words = (state_q == ST_IDLE) ? 7'(N_WORDS) : words_left_q;
  assign next_len  = burst_len(src_words, src_addr[11:0]);

  assign rready_m_inf = (state_q == ST_R) && !fifo_full;
  assign r_fire       = rvalid_m_inf && rready_m_inf;
  assign fifo_pop     = out_valid && out_ready;
  assign last_beat    = (beats_left_q == '0);
  // The beat counter, not rlast, ends a burst; a misplaced rlast only flags err.
  assign beat_err     = (rresp_m_inf != RESP_OKAY) || (rid_m_inf != '0) ||
                        (rlast_m_inf != last_beat);

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    araddr_d     = araddr_q;
    words_left_d = words_left_q;
    arlen_d      = arlen_q;
    beats_left_d = beats_left_q;
    push_idx_d   = push_idx_q;
    err_d        = err_q;
    done_d       = 1'b0;
    load_burst   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        load_burst = 1'b1;
        push_idx_d = '0;
        err_d      = 1'b0;
        state_d    = ST_AR;
      end
      ST_AR: if (arready_m_inf) begin
        beats_left_d = arlen_q;
        state_d      = ST_R;
      end
      ST_R: if (r_fire) begin
        push_idx_d = push_idx_q + 6'd1;
        if (beat_err) err_d = 1'b1;
        if (!last_beat) begin
          beats_left_d = beats_left_q - 4'd1;
        end else if (words_left_q != '0) begin
          load_burst = 1'b1;
          state_d    = ST_AR;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (fifo_empty || (fifo_pop && fifo_count == CNT_W'(1))) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_burst) begin
      araddr_d     = src_addr;
      arlen_d      = 4'(next_len - 5'd1);
      cur_addr_d   = src_addr + ADDR_WIDTH'({next_len, 2'b00});
      words_left_d = src_words - 7'(next_len);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      araddr_q     <= '0;
      words_left_q <= '0;
      arlen_q      <= '0;
      beats_left_q <= '0;
      push_idx_q   <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      araddr_q     <= araddr_d;
      words_left_q <= words_left_d;
      arlen_q      <= arlen_d;
      beats_left_q <= beats_left_d;
      push_idx_q   <= push_idx_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  glcm_word_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_fire),
    .wdata ({push_idx_q, rdata_m_inf}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign arid_m_inf    = '0;
  assign araddr_m_inf  = araddr_q;
  assign arlen_m_inf   = arlen_q;
  assign arsize_m_inf  = AXSIZE_4B;
  assign arburst_m_inf = AXBURST_INCR;
  assign arvalid_m_inf = (state_q == ST_AR);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign out_valid     = !fifo_empty;
  assign out_data      = fifo_rdata[DATA_WIDTH-1:0];
  assign out_idx       = fifo_rdata[FIFO_W-1 -: 6];

endmodule

// File: tb/tb_glcm_matrix_reader.sv
// Directed bench for glcm_matrix_reader: AXI slave model with fault injection,
// scoreboard of expected words and expected AR commands.
module tb_glcm_matrix_reader;
  import glcm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done, err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_idx;

  glcm_matrix_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen),
    .arsize_m_inf(arsize), .arburst_m_inf(arburst),
    .arvalid_m_inf(arvalid), .arready_m_inf(arready),
    .rid_m_inf(rid), .rdata_m_inf(rdata), .rresp_m_inf(rresp),
    .rlast_m_inf(rlast), .rvalid_m_inf(rvalid), .rready_m_inf(rready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [5:0] idx; logic [31:0] data; } word_t;
  typedef struct { logic [31:0] addr; logic [3:0] len; } ar_t;

  word_t exp_q[$];
  ar_t   ar_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] seed = 32'h1234_5678;
  bit          rand_mode = 1'b0;
  int          err_burst = -1, err_beat = -1;
  int          rl_burst = -1, rl_beat = -1;
  int          n_pops = 0;
  int          last_pop_cyc = -10;
  int          burst_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // AXI slave: decisions at negedge (stable handshake), drives just after posedge.
  initial begin : axi_slave
    bit          ar_fire, r_fire, rst_seen, r_active, gap_pending;
    logic [31:0] a_addr, r_addr;
    logic [3:0]  a_len, r_len, r_beat;
    int          cur_burst;
    ar_t         e;
    r_active = 1'b0; gap_pending = 1'b0; r_addr = '0; r_len = '0; r_beat = '0; cur_burst = 0;
    forever begin
      @(negedge clk);
      rst_seen = !rst_n;
      ar_fire  = rst_n && arvalid && arready;
      r_fire   = rst_n && rvalid && rready;
      a_addr   = araddr;
      a_len    = arlen;
      if (rst_n && gap_pending) begin
        check("ar_after_last_beat", arvalid, 1);
        gap_pending = 1'b0;
      end
      if (ar_fire) begin
        check("ar_single_outstanding", r_active, 0);
        check("ar_expected", ar_q.size() > 0, 1);
        if (ar_q.size() > 0) begin
          e = ar_q.pop_front();
          check("araddr", a_addr, e.addr);
          check("arlen", a_len, e.len);
        end
        check("arid", arid, 0);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
      end
      @(posedge clk);
      #1;
      if (rst_seen) begin
        r_active = 1'b0; gap_pending = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0;
      end else begin
        if (ar_fire) begin
          r_active = 1'b1; r_addr = a_addr; r_len = a_len; r_beat = '0;
          cur_burst = burst_cnt; burst_cnt++;
        end
        if (r_fire) begin
          if (r_beat == r_len) begin
            r_active    = 1'b0;
            gap_pending = !rand_mode && (ar_q.size() > 0);
          end else begin
            r_beat++;
          end
        end
        arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        rvalid  = (rvalid && !r_fire) ? 1'b1 :
                  (r_active && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1));
        rdata   = mem_word(r_addr + 32'(r_beat) * 32'd4);
        rresp   = (cur_burst == err_burst && int'(r_beat) == err_beat) ? 2'b10 : 2'b00;
        rlast   = (r_beat == r_len) || (cur_burst == rl_burst && int'(r_beat) == rl_beat);
      end
    end
  end

  // Output monitor: pops the scoreboard on every accepted word.
  initial begin : out_monitor
    bit          hold_chk;
    logic [31:0] hold_data;
    logic [5:0]  hold_idx;
    word_t       w;
    hold_chk = 1'b0; hold_data = '0; hold_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hold_data);
          check("hold_idx", out_idx, hold_idx);
        end
        hold_chk  = out_valid && !out_ready;
        hold_data = out_data;
        hold_idx  = out_idx;
        if (out_valid && out_ready) begin
          n_pops++;
          check("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("out_data", out_data, w.data);
            check("out_idx", out_idx, w.idx);
            if (w.idx == 6'd63) last_pop_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic push_ar(input logic [31:0] addr, input logic [3:0] len);
    ar_t a;
    a.addr = addr;
    a.len  = len;
    ar_q.push_back(a);
  endtask

  task automatic push_ar_1000();
    push_ar(32'h1000, 4'd15); push_ar(32'h1040, 4'd15);
    push_ar(32'h1080, 4'd15); push_ar(32'h10C0, 4'd15);
  endtask

  task automatic start_run(input logic [31:0] base);
    word_t w;
    seed      = $urandom;
    burst_cnt = 0;
    n_pops    = 0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      w.idx  = 6'(i);
      w.data = mem_word(base + 32'(4 * i));
      exp_q.push_back(w);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(negedge clk);
    check("busy_before_start", busy, 0);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 32'hDEAD_BEE0;
    @(negedge clk);
    check("start_arvalid", arvalid, 1);
    check("start_busy", busy, 1);
    check("start_err_clear", err, 0);
  endtask

  task automatic wait_pops(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && n_pops < n; i++) @(negedge clk);
    check("pops_reached", n_pops >= n, 1);
  endtask

  task automatic wait_done(input bit exp_err, input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      got = (done === 1'b1);
    end
    check("done_seen", got, 1);
    if (got) begin
      check("done_after_last_pop", cyc, last_pop_cyc + 1);
      check("done_busy_low", busy, 0);
    end
    check("err_at_done", err, exp_err);
    check("words_outstanding", exp_q.size(), 0);
    check("ars_outstanding", ar_q.size(), 0);
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_state", dut.state_q, ST_IDLE);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Aligned base, no stalls: four full bursts back to back.
    rand_mode = 1'b0;
    push_ar_1000();
    start_run(32'h1000);
    wait_done(1'b0, 2000);

    // Base near a page end: short first burst, single-beat tail burst.
    rand_mode = 1'b1;
    push_ar(32'h1FC4, 4'd14); push_ar(32'h2000, 4'd15); push_ar(32'h2040, 4'd15);
    push_ar(32'h2080, 4'd15); push_ar(32'h20C0, 4'd0);
    start_run(32'h1FC4);
    wait_done(1'b0, 3000);

    // Downstream stall mid-burst: rready must drop with the FIFO full.
    rand_mode = 1'b0;
    push_ar_1000();
    start_run(32'h1000);
    wait_pops(10, 500);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("stall_rready_low", rready, 0);
    check("stall_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(1'b0, 2000);

    // SLVERR on beat 5 of the second burst: sticky err, all words delivered.
    err_burst = 1; err_beat = 5;
    push_ar_1000();
    start_run(32'h1000);
    wait_done(1'b1, 2000);
    err_burst = -1; err_beat = -1;

    // Early rlast on beat 10 of the first burst; start must clear err.
    rl_burst = 0; rl_beat = 10;
    push_ar_1000();
    start_run(32'h1000);
    wait_done(1'b1, 2000);
    rl_burst = -1; rl_beat = -1;

    // One-cycle reset mid-burst.
    push_ar_1000();
    start_run(32'h1000);
    wait_pops(20, 500);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    ar_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    // Fresh run after reset, with page split in the second burst.
    rand_mode = 1'b1;
    push_ar(32'h2F88, 4'd15); push_ar(32'h2FC8, 4'd13); push_ar(32'h3000, 4'd15);
    push_ar(32'h3040, 4'd15); push_ar(32'h3080, 4'd1);
    start_run(32'h2F88);
    wait_done(1'b0, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
